mtm_alu_core_arbiter: RTL
=========================

// Module: mtm_alu_core_arbiter
// PURPOSE
//  Shares one mtm_Alu core + serializer pair between two operand requesters (two deserializer channels).
//  Round-robin grant; latches the winner's A/B/opmode, drives the combinational core, pulses the serializer start.
//  Waits for the serializer frame to complete before the next grant; times out if the serializer never responds.
// PARAMETERS
//  DATA_W       32  operand width (A, B)
//  OP_W         3   opmode width
//  ACK_TIMEOUT  15  max cycles in WAIT_ACK for ser_busy to rise before abort (1..255)
// PORTS
//  clk          in   1       posedge clock
//  rst_n        in   1       asynchronous active-low reset
//  req0_valid   in   1       requester 0 has an operation
//  req0_ready   out  1       requester 0 accepted this cycle (valid&ready)
//  req0_A       in   DATA_W  requester 0 operand A
//  req0_B       in   DATA_W  requester 0 operand B
//  req0_op      in   OP_W    requester 0 opmode
//  req1_*       -    -       same set for requester 1
//  core_A       out  DATA_W  registered operand A to core
//  core_B       out  DATA_W  registered operand B to core
//  core_op      out  OP_W    registered opmode to core
//  ser_start    out  1       one-cycle start (t_valid) to serializer
//  ser_busy     in   1       serializer transmitting a frame
//  gnt_id       out  1       requester owning the current operation
//  busy         out  1       arbiter not in IDLE
//  err_timeout  out  1       one-cycle pulse: serializer did not acknowledge, operation dropped
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; core_A/B/op=0, ser_start=0, gnt_id=0, busy=0, err_timeout=0,
//   last_gnt=1 (req0 wins first tie), timeout counter=0. reqN_ready gated by rst_n (0 in reset).
//  FSM: IDLE -> EXEC -> START -> WAIT_ACK -> WAIT_DONE -> IDLE.
//  IDLE: if ser_busy=0 and any reqN_valid, select winner: single valid wins; both valid -> requester
//   != last_gnt. reqN_ready=1 combinationally for winner only; at the clock edge latch winner's
//   A/B/op into core_*, set gnt_id=winner, last_gnt=winner, -> EXEC. If ser_busy=1, no ready, stay.
//  EXEC: one cycle; core operands stable, core result settles. -> START.
//  START: ser_start=1 for exactly this cycle; clear counter. -> WAIT_ACK.
//  WAIT_ACK: ser_busy=1 -> WAIT_DONE. Else counter++; when counter reaches ACK_TIMEOUT without
//   ser_busy: err_timeout=1 next cycle (one cycle), -> IDLE.
//  WAIT_DONE: stay while ser_busy=1; ser_busy=0 -> IDLE.
//  Latency: handshake in cycle T -> core_* valid T+1 -> ser_start high in T+2.
//  core_*/gnt_id hold their value outside IDLE accept edges (stable through the serializer frame).
//  busy=1 in every state except IDLE. reqN_ready=0 in every state except IDLE.
//  Requesters hold valid and data stable until ready; no ready -> no state change for that requester.
//  Back-to-back: the IDLE cycle after WAIT_DONE may accept immediately (min 1 IDLE cycle between ops).
//  Starvation-free: with both valid continuously, grants alternate 0,1,0,1,...
//  Reset mid-operation: any state -> IDLE asynchronously; ser_start drops immediately; op lost;
//   last_gnt returns to 1.
// TESTING
//  T1 single op: req0 A=32'h0000_0005 B=32'h0000_0003 op=3'b001 -> req0_ready 1 cycle, core_* match
//     at T+1, ser_start single pulse at T+2, gnt_id=0; ser_busy 1 for 10 cycles -> busy drops after.
//  T2 contention: req0 and req1 valid same cycle after reset -> grant order 0,1,0,1 over 4 ops;
//     each loser's ready stays 0 until its turn.
//  T3 timeout: ser_busy tied 0 after ser_start -> err_timeout pulse exactly ACK_TIMEOUT(15) cycles
//     after WAIT_ACK entry, FSM back to IDLE, next request accepted.
//  T4 serializer busy in IDLE: ser_busy=1, req1 valid -> no ready; ser_busy falls -> ready next cycle.
//  T5 reset mid-WAIT_DONE: assert rst_n=0 between clock edges -> all outputs zero without waiting
//     for clk; after release req0 wins a tie first.
//  T6 stability: change req0_A while in WAIT_DONE -> core_A unchanged until next accept.

Source files
------------

// File: rtl/mtm_alu_core_arbiter.sv
// Round-robin arbiter sharing one mtm_Alu core and serializer between two requesters.
// Latches the winner's operands, pulses the serializer start and waits for the frame to finish.
module mtm_alu_core_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] core_A,
  output logic [DATA_W-1:0] core_B,
  output logic [OP_W-1:0]   core_op,
  output logic              ser_start,
  input  logic              ser_busy,
  output logic              gnt_id,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   core_a_q, core_a_d;
  logic [DATA_W-1:0]   core_b_q, core_b_d;
  logic [OP_W-1:0]     core_op_q, core_op_d;
  logic                ser_start_q, ser_start_d;
  logic                gnt_q, gnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_c;
  logic                ready0_c;
  logic                ready1_c;

  // On a tie the requester that did not win last time gets the grant.
  assign win_c = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;

  always_comb begin
    state_d     = state_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_op_d   = core_op_q;
    ser_start_d = 1'b0;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ser_busy && (req0_valid || req1_valid)) begin
          ready0_c   = ~win_c;
          ready1_c   = win_c;
          core_a_d   = win_c ? req1_A  : req0_A;
          core_b_d   = win_c ? req1_B  : req0_B;
          core_op_d  = win_c ? req1_op : req0_op;
          gnt_d      = win_c;
          last_gnt_d = win_c;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        ser_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ser_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!ser_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_op_q   <= '0;
      ser_start_q <= 1'b0;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_op_q   <= core_op_d;
      ser_start_q <= ser_start_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req0_ready  = rst_n & ready0_c;
  assign req1_ready  = rst_n & ready1_c;
  assign core_A      = core_a_q;
  assign core_B      = core_b_q;
  assign core_op     = core_op_q;
  assign ser_start   = ser_start_q;
  assign gnt_id      = gnt_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
